// File: rtl/arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Optional round-robin arbitration is enabled with FAIR_ARB_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IF_BUSY = 2'b01,
    DM_BUSY = 2'b10
  } arb_state_e;

  localparam logic [15:0] NOP_INST    = 16'h0800;
  localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Pipeline and memory-side bundle of the fetch/data memory arbiter.
// slave = arbiter view, master = pipeline plus memory environment view.
interface imem_dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_data;
  logic              if_stall;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;
  logic              mem_start;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              err;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_rd, dm_wr, dm_addr, dm_wdata,
    input  mem_rdata, mem_done,
    output if_valid, if_data, if_stall,
    output dm_valid, dm_rdata, dm_stall,
    output mem_start, mem_wr, mem_addr, mem_wdata,
    output err
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_rd, dm_wr, dm_addr, dm_wdata,
    output mem_rdata, mem_done,
    input  if_valid, if_data, if_stall,
    input  dm_valid, dm_rdata, dm_stall,
    input  mem_start, mem_wr, mem_addr, mem_wdata,
    input  err
  );

endinterface

// File: rtl/arb_timeout_cnt.sv
// 4-bit access watchdog: clear, count while enabled, flag on reaching LIMIT.
module arb_timeout_cnt #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the busy cycle whose closing edge brings the count to LIMIT.
  assign expire_o = en_i & ~clr_i & ((cnt_q + 4'd1) == 4'(LIMIT));

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Fetch/data arbiter for one single-ported multi-cycle unified memory.
// Macro FAIR_ARB_EN selects round-robin instead of fixed data priority.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  imem_dmem_arbiter_if.slave bus
);

  arb_state_e        state_q;
  logic              mem_start_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] if_data_q;
  logic              dm_valid_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              kill_q;
  logic              ret_q;
  logic              err_q;

  logic dm_req, if_ok, pick_dm;
  logic grant_dm, grant_if;
  logic busy, expire;

  assign dm_req = bus.dm_rd | bus.dm_wr;
  assign if_ok  = bus.if_req & ~bus.if_flush;

`ifdef FAIR_ARB_EN
  logic last_dm_q;
  assign pick_dm = dm_req & (~if_ok | ~last_dm_q);
`else
  assign pick_dm = dm_req;
`endif

  // ret_q marks the return cycle, which never starts a new access.
  assign grant_dm = (state_q == IDLE) & ~ret_q & pick_dm;
  assign grant_if = (state_q == IDLE) & ~ret_q & if_ok & ~pick_dm;
  assign busy     = (state_q != IDLE);

  arb_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (grant_dm | grant_if),
    .en_i    (busy),
    .expire_o(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_start_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_data_q   <= '0;
      dm_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      kill_q      <= 1'b0;
      ret_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef FAIR_ARB_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      mem_start_q <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      ret_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_dm) begin
            state_q     <= DM_BUSY;
            mem_start_q <= 1'b1;
            mem_addr_q  <= bus.dm_addr;
            mem_wr_q    <= bus.dm_wr;
            mem_wdata_q <= bus.dm_wdata;
            if (bus.dm_rd && bus.dm_wr) err_q <= 1'b1;
`ifdef FAIR_ARB_EN
            last_dm_q   <= 1'b1;
`endif
          end else if (grant_if) begin
            state_q     <= IF_BUSY;
            mem_start_q <= 1'b1;
            mem_addr_q  <= bus.if_addr;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
`ifdef FAIR_ARB_EN
            last_dm_q   <= 1'b0;
`endif
          end
        end
        IF_BUSY, DM_BUSY: begin
          if (bus.mem_done) begin
            state_q  <= IDLE;
            ret_q    <= 1'b1;
            mem_wr_q <= 1'b0;
            kill_q   <= 1'b0;
            if (state_q == DM_BUSY) begin
              dm_valid_q <= 1'b1;
              dm_rdata_q <= mem_wr_q ? '0 : bus.mem_rdata;
            end else if (!kill_q && !bus.if_flush) begin
              if_valid_q <= 1'b1;
              if_data_q  <= bus.mem_rdata;
            end else begin
              if_data_q  <= DATA_W'(NOP_INST);
            end
          end else if (expire) begin
            state_q  <= IDLE;
            mem_wr_q <= 1'b0;
            kill_q   <= 1'b0;
            err_q    <= 1'b1;
          end else if (state_q == IF_BUSY && bus.if_flush) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_start = mem_start_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_data   = if_data_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.err       = err_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: vector table, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_imem_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_dmem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: written words, otherwise a fixed address hash.
  logic [15:0] mem_m [logic [15:0]];
  logic [15:0] ref_m [logic [15:0]];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_m.exists(a)) return ref_m[a];
    return dflt(a);
  endfunction

  int lat_cfg = 1;

  // Memory: mem_done 'lat' cycles after the cycle mem_start is seen.
  initial begin : responder
    int cnt;
    bit pend;
    bit pw;
    logic [15:0] pa, pwd;
    pend = 0;
    cnt = 0;
    pw = 0;
    pa = '0;
    pwd = '0;
    bus.mem_done = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_done = 1'b1;
          pend = 0;
          if (pw) begin
            mem_m[pa] = pwd;
            bus.mem_rdata = 16'($urandom);
          end else begin
            bus.mem_rdata = mem_m.exists(pa) ? mem_m[pa] : dflt(pa);
          end
        end
      end
      if (bus.mem_start) begin
        pend = 1;
        cnt = (lat_cfg == 0) ? $urandom_range(1, 4) : lat_cfg;
        pa = bus.mem_addr;
        pw = bus.mem_wr;
        pwd = bus.mem_wdata;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] pre;
    bit          has_pre;
    int          lat;
    logic [15:0] exp_out;
  } vec_t;

  task automatic idle_inputs();
    bus.if_req = 0;
    bus.if_flush = 0;
    bus.if_addr = '0;
    bus.dm_rd = 0;
    bus.dm_wr = 0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
  endtask

  // kind: 0 fetch, 1 read, 2 write
  task automatic run_vec(input vec_t v);
    int t0, tv;
    bit held, stall_ok, vld, stl;
    if (v.has_pre) mem_m[v.addr] = v.pre;
    lat_cfg = v.lat;
    if (v.kind == 0) begin
      bus.if_req = 1;
      bus.if_addr = v.addr;
    end else begin
      bus.dm_rd = (v.kind == 1);
      bus.dm_wr = (v.kind == 2);
      bus.dm_addr = v.addr;
      bus.dm_wdata = v.wdata;
    end
    t0 = -1;
    tv = -1;
    held = 1;
    stall_ok = 1;
    for (int c = 0; c < 40 && tv < 0; c++) begin
      @(negedge clk);
      vld = (v.kind == 0) ? bus.if_valid : bus.dm_valid;
      stl = (v.kind == 0) ? bus.if_stall : bus.dm_stall;
      if (bus.mem_start && t0 < 0) begin
        t0 = c;
        chk("vec mem_addr", bus.mem_addr, v.addr);
        chk("vec mem_wr", bus.mem_wr, (v.kind == 2));
      end
      if (t0 >= 0 && !vld && v.kind == 2)
        held &= (bus.mem_wr == 1'b1) && (bus.mem_wdata == v.wdata);
      if (vld) tv = c;
      stall_ok &= (stl == !vld);
    end
    chk("vec started", (t0 >= 0), 1);
    chk("vec valid seen", (tv >= 0), 1);
    chk("vec latency", tv - t0, v.lat + 1);
    chk("vec data", (v.kind == 0) ? bus.if_data : bus.dm_rdata, v.exp_out);
    chk("vec stall", stall_ok, 1);
    if (v.kind == 2) begin
      chk("vec wr held", held, 1);
      ref_m[v.addr] = v.wdata;
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin : main
    vec_t vt[6];
    logic [15:0] first_addr;
    logic [15:0] exp_first;
    bit got_d, got_i, bad, seen40, ok, stall_ok;
    bit fr, dr, dw, gf, gd;
    logic [15:0] fa, da, dwd;
    int t0, nf, nd;

    idle_inputs();
    vt[0] = '{0, 16'h0010, 16'h0000, 16'hA5A5, 1, 3, 16'hA5A5};
    vt[1] = '{1, 16'h0100, 16'h0000, 16'h1234, 1, 1, 16'h1234};
    vt[2] = '{2, 16'h0200, 16'hBEEF, 16'h0000, 0, 2, 16'h0000};
    vt[3] = '{1, 16'h0200, 16'h0000, 16'h0000, 0, 2, 16'hBEEF};
    vt[4] = '{0, 16'h0030, 16'h0000, 16'h0000, 0, 1, dflt(16'h0030)};
    vt[5] = '{2, 16'h0210, 16'h0001, 16'h0000, 0, 4, 16'h0000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset outs", {bus.mem_start, bus.mem_wr, bus.mem_addr,
                       bus.mem_wdata[14:0]}, 0);
    rst = 0;
    @(negedge clk);
    chk("idle valids/err", {bus.if_valid, bus.dm_valid, bus.err,
                            bus.if_stall, bus.dm_stall}, 0);
    chk("idle data", {bus.if_data, bus.dm_rdata}, 0);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Both request together: data first unless round-robin favours fetch
`ifdef FAIR_ARB_EN
    exp_first = 16'h0050;
`else
    exp_first = 16'h0100;
`endif
    lat_cfg = 2;
    mem_m[16'h0100] = 16'h4321;
    bus.if_req = 1;
    bus.if_addr = 16'h0050;
    bus.dm_rd = 1;
    bus.dm_addr = 16'h0100;
    first_addr = 16'hFFFF;
    got_d = 0;
    got_i = 0;
    for (int c = 0; c < 60 && !(got_d && got_i); c++) begin
      @(negedge clk);
      if (bus.mem_start && first_addr == 16'hFFFF) first_addr = bus.mem_addr;
      if (bus.dm_valid) begin
        chk("simul dm_rdata", bus.dm_rdata, 16'h4321);
        got_d = 1;
        bus.dm_rd = 0;
      end
      if (bus.if_valid) begin
        chk("simul if_data", bus.if_data, dflt(16'h0050));
        got_i = 1;
        bus.if_req = 0;
      end
    end
    chk("simul first grant", first_addr, exp_first);
    chk("simul both done", {got_d, got_i}, 2'b11);
    idle_inputs();
    @(negedge clk);

    // Flush one cycle after mem_start, then fetch the redirect target
    lat_cfg = 3;
    mem_m[16'h0040] = 16'h7777;
    bus.if_req = 1;
    bus.if_addr = 16'h0020;
    t0 = -1;
    for (int c = 0; c < 10 && t0 < 0; c++) begin
      @(negedge clk);
      if (bus.mem_start) t0 = c;
    end
    chk("flush start", (t0 >= 0) && (bus.mem_addr == 16'h0020), 1);
    @(negedge clk);
    bus.if_flush = 1;
    @(negedge clk);
    bus.if_flush = 0;
    bus.if_addr = 16'h0040;
    bad = 0;
    seen40 = 0;
    got_i = 0;
    for (int c = 0; c < 30 && !got_i; c++) begin
      @(negedge clk);
      if (bus.mem_start && bus.mem_addr == 16'h0040) seen40 = 1;
      if (bus.if_valid) begin
        if (!seen40) bad = 1;
        chk("flush next data", bus.if_data, 16'h7777);
        got_i = 1;
        bus.if_req = 0;
      end
    end
    chk("flush killed no valid", bad, 0);
    chk("flush next returned", got_i, 1);
    idle_inputs();
    @(negedge clk);

    // Flush in the grant cycle suppresses the fetch grant
    bus.if_req = 1;
    bus.if_addr = 16'h0060;
    bus.if_flush = 1;
    @(negedge clk);
    chk("flush grant suppressed", bus.mem_start, 0);
    idle_inputs();
    @(negedge clk);
    chk("flush grant still idle", bus.mem_start, 0);

    // Timeout: memory never answers in time
    lat_cfg = 40;
    bus.dm_rd = 1;
    bus.dm_addr = 16'h0300;
    t0 = -1;
    for (int c = 0; c < 10 && t0 < 0; c++) begin
      @(negedge clk);
      if (bus.mem_start) t0 = c;
    end
    chk("tmo start", (t0 >= 0), 1);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.dm_valid) bad = 1;
      if (k == 14) chk("tmo err before", bus.err, 0);
      if (k == 15) begin
        chk("tmo err at 15", bus.err, 1);
        bus.dm_rd = 0;
      end
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.dm_valid || bus.mem_start) bad = 1;
    end
    chk("tmo no valid/restart", bad, 0);
    chk("tmo err sticky", bus.err, 1);

    // Async reset in the middle of a data access
    lat_cfg = 5;
    bus.dm_wr = 1;
    bus.dm_addr = 16'h0400;
    bus.dm_wdata = 16'h5555;
    t0 = -1;
    for (int c = 0; c < 10 && t0 < 0; c++) begin
      @(negedge clk);
      if (bus.mem_start) t0 = c;
    end
    chk("rst access started", (t0 >= 0), 1);
    @(negedge clk);
    #2;
    rst = 1;
    idle_inputs();
    #1;
    chk("rst mem outs", {bus.mem_start, bus.mem_wr, bus.mem_addr,
                         bus.mem_wdata[14:0]}, 0);
    chk("rst flags", {bus.err, bus.dm_valid, bus.if_valid,
                      bus.dm_stall, bus.if_stall}, 0);
    @(negedge clk);
    rst = 0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.dm_valid || bus.mem_start) bad = 1;
    end
    chk("rst late done ignored", bad, 0);

    // Read and write together: error, handled as a write
    lat_cfg = 1;
    bus.dm_rd = 1;
    bus.dm_wr = 1;
    bus.dm_addr = 16'h0500;
    bus.dm_wdata = 16'h1111;
    got_d = 0;
    for (int c = 0; c < 20 && !got_d; c++) begin
      @(negedge clk);
      if (bus.mem_start) chk("rdwr mem_wr", bus.mem_wr, 1);
      if (bus.dm_valid) begin
        got_d = 1;
        chk("rdwr rdata", bus.dm_rdata, 0);
      end
    end
    chk("rdwr err", {got_d, bus.err}, 2'b11);
    idle_inputs();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rdwr err cleared", bus.err, 0);

    // Randomized traffic against a transaction-level model
    lat_cfg = 0;
    fr = 0; dr = 0; dw = 0;
    fa = '0; da = '0; dwd = '0;
    nf = 0; nd = 0;
    ok = 1;
    stall_ok = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      gf = 0;
      gd = 0;
      stall_ok &= (bus.if_stall == (fr && !bus.if_valid));
      stall_ok &= (bus.dm_stall == ((dr || dw) && !bus.dm_valid));
      if (bus.mem_start)
        ok &= (fr && bus.mem_addr == fa && !bus.mem_wr) ||
              ((dr || dw) && bus.mem_addr == da && bus.mem_wr == dw &&
               (!dw || bus.mem_wdata == dwd));
      if (bus.if_valid) begin
        chk("rnd if_data", bus.if_data, ref_rd(fa));
        fr = 0;
        gf = 1;
        nf++;
      end
      if (bus.dm_valid) begin
        if (dw) begin
          chk("rnd wr rdata", bus.dm_rdata, 0);
          ref_m[da] = dwd;
        end else begin
          chk("rnd rd rdata", bus.dm_rdata, ref_rd(da));
        end
        dr = 0;
        dw = 0;
        gd = 1;
        nd++;
      end
      if (cyc < 300) begin
        if (!fr && !gf && $urandom_range(0, 2) == 0) begin
          fr = 1;
          fa = {13'd0, 3'($urandom_range(0, 7))};
        end
        if (!dr && !dw && !gd && $urandom_range(0, 2) == 0) begin
          dw = $urandom_range(0, 1) == 1;
          dr = !dw;
          da = {13'd0, 3'($urandom_range(0, 7))};
          dwd = 16'($urandom);
        end
      end else if (!fr && !dr && !dw) begin
        break;
      end
      bus.if_req = fr;
      bus.if_addr = fa;
      bus.dm_rd = dr;
      bus.dm_wr = dw;
      bus.dm_addr = da;
      bus.dm_wdata = dwd;
    end
    chk("rnd drained", {fr, dr, dw}, 0);
    chk("rnd starts match", ok, 1);
    chk("rnd stalls", stall_ok, 1);
    chk("rnd both served", (nf > 0) && (nd > 0), 1);
    chk("rnd no err", bus.err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
